// File: rtl/mp_shared_pkg.sv
// mp_shared_pkg: shared types and default sizes for the mp_shared_exec unit.
//   op_e    - 3-bit opcode encoding (ADD..MEM)
//   state_e - transaction FSM states (IDLE -> GRANT -> RESP)
//   MP_AW / MP_DW / MP_CIDW - default address, data and core-ID widths
package mp_shared_pkg;

  localparam int unsigned MP_AW   = 11;
  localparam int unsigned MP_DW   = 8;
  localparam int unsigned MP_CIDW = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSVD = 3'b110,
    OP_MEM  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/mp_alu.sv
// mp_alu: combinational DW-bit ALU for opcodes 000-110 (MEM yields 0 here;
// the top module supplies the memory result).
// Ports:
//   i_a, i_b : operands
//   i_op     : opcode
//   o_r_c    : result, modulo 2^DW
// Build option: define MP_SAT_ALU_EN to make ADD/SUB saturate unsigned.
import mp_shared_pkg::*;

module mp_alu #(
  parameter int unsigned DW = MP_DW
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  op_e           i_op,
  output logic [DW-1:0] o_r_c
);

  logic [DW-1:0] w_add;
  logic [DW-1:0] w_sub;

`ifdef MP_SAT_ALU_EN
  // Carry out of the widened sum means overflow -> clamp to all ones.
  logic [DW:0] w_sum;
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_add = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
  assign w_sub = (i_a < i_b) ? '0 : (i_a - i_b);
`else
  assign w_add = i_a + i_b;
  assign w_sub = i_a - i_b;
`endif

  // Result select.
  always_comb begin
    o_r_c = '0;
    case (i_op)
      OP_ADD:  o_r_c = w_add;
      OP_SUB:  o_r_c = w_sub;
      OP_AND:  o_r_c = i_a & i_b;
      OP_OR:   o_r_c = i_a | i_b;
      OP_XOR:  o_r_c = i_a ^ i_b;
      OP_MUL:  o_r_c = i_a * i_b;
      default: o_r_c = '0;
    endcase
  end

endmodule

// File: rtl/mp_shared_exec.sv
// mp_shared_exec: shared execution unit (ALU + 2^AW x DW memory) serving
// several cores. Each accepted request goes IDLE -> GRANT -> RESP -> IDLE,
// pulsing gnt then rvalid, with the requester's ID echoed on core_id_out.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   core_id, opcode,
//   req, addr, A, B, we : request bus (sampled only in IDLE)
//   gnt                 : request accepted pulse
//   rvalid, data_out,
//   core_id_out         : response pulse, data and requester ID
// Build option: MP_SAT_ALU_EN (saturating ADD/SUB, handled in mp_alu).
import mp_shared_pkg::*;

module mp_shared_exec #(
  parameter int unsigned AW   = MP_AW,
  parameter int unsigned DW   = MP_DW,
  parameter int unsigned CIDW = MP_CIDW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CIDW-1:0] core_id,
  input  logic [2:0]      opcode,
  input  logic            req,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic            we,
  output logic            gnt,
  output logic            rvalid,
  output logic [DW-1:0]   data_out,
  output logic [CIDW-1:0] core_id_out
);

  localparam int unsigned DEPTH = 2 ** AW;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [CIDW-1:0] r_core_id;
  op_e             r_op;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic            r_we;

  logic            r_gnt;
  logic            r_rvalid;
  logic [DW-1:0]   r_data_out;
  logic [CIDW-1:0] r_core_id_out;

  logic            w_gnt_nxt;
  logic            w_rvalid_nxt;
  logic [DW-1:0]   w_data_nxt;
  logic [CIDW-1:0] w_cid_nxt;
  logic            w_cap;
  logic            w_mem_we;

  logic [DW-1:0]   w_alu_r;
  logic [DW-1:0]   w_mem_rd;
  logic [DW-1:0]   w_result;

  logic [DW-1:0]   r_mem [DEPTH];

  mp_alu #(.DW(DW)) u_alu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_r_c (w_alu_r)
  );

  // Read sees the pre-transaction contents; the write lands at the same edge.
  assign w_mem_rd = r_mem[r_addr];
  assign w_result = (r_op == OP_MEM) ? (r_we ? r_a : w_mem_rd) : w_alu_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = 1'b0;
    w_rvalid_nxt = 1'b0;
    w_data_nxt   = r_data_out;
    w_cid_nxt    = r_core_id_out;
    w_cap        = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 1'b1;
          w_cap       = 1'b1;
        end
      end
      ST_GRANT: begin
        w_state_nxt  = ST_RESP;
        w_rvalid_nxt = 1'b1;
        w_data_nxt   = w_result;
        w_cid_nxt    = r_core_id;
        w_mem_we     = r_we;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_core_id     <= '0;
      r_op          <= OP_ADD;
      r_addr        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_we          <= 1'b0;
      r_gnt         <= 1'b0;
      r_rvalid      <= 1'b0;
      r_data_out    <= '0;
      r_core_id_out <= '0;
    end else begin
      if (w_cap) begin
        r_core_id <= core_id;
        r_op      <= op_e'(opcode);
        r_addr    <= addr;
        r_a       <= A;
        r_b       <= B;
        r_we      <= we;
      end
      r_gnt         <= w_gnt_nxt;
      r_rvalid      <= w_rvalid_nxt;
      r_data_out    <= w_data_nxt;
      r_core_id_out <= w_cid_nxt;
    end
  end

  // Data memory, not reset; a reset at the write edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) r_mem[r_addr] <= w_result;
  end

  assign gnt         = r_gnt;
  assign rvalid      = r_rvalid;
  assign data_out    = r_data_out;
  assign core_id_out = r_core_id_out;

endmodule

// File: tb/tb_mp_shared_exec.sv
// tb_mp_shared_exec: self-checking bench for mp_shared_exec. Directed
// scenarios plus randomized transactions compared against an arithmetic
// reference model with an associative-array memory.
module tb_mp_shared_exec;

  localparam int unsigned AW   = 11;
  localparam int unsigned DW   = 8;
  localparam int unsigned CIDW = 2;

  logic            clk;
  logic            rst_n;
  logic [CIDW-1:0] core_id;
  logic [2:0]      opcode;
  logic            req;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   A;
  logic [DW-1:0]   B;
  logic            we;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   data_out;
  logic [CIDW-1:0] core_id_out;

  int n_checks;
  int n_errors;

  // Reference memory: only addresses written during the run are known.
  int mem_m [int];

  mp_shared_exec #(.AW(AW), .DW(DW), .CIDW(CIDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_id     (core_id),
    .opcode      (opcode),
    .req         (req),
    .addr        (addr),
    .A           (A),
    .B           (B),
    .we          (we),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .data_out    (data_out),
    .core_id_out (core_id_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int alu_model(input int op, input int a, input int b);
    int s;
    case (op)
      0: begin
        s = a + b;
`ifdef MP_SAT_ALU_EN
        return (s > 255) ? 255 : s;
`else
        return s % 256;
`endif
      end
      1: begin
`ifdef MP_SAT_ALU_EN
        return (a < b) ? 0 : a - b;
`else
        return (a - b + 256) % 256;
`endif
      end
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * b) % 256;
      default: return 0;
    endcase
  endfunction

  // Expected response for one transaction; updates the memory model.
  function automatic int model_exec(input int op, input int ad, input int a, input int b, input bit w);
    int r;
    if (op == 7) r = w ? a : (mem_m.exists(ad) ? mem_m[ad] : 0);
    else         r = alu_model(op, a, b);
    if (w) mem_m[ad] = r;
    return r;
  endfunction

  // One full transaction with the cycle-by-cycle handshake checked.
  task automatic do_txn(input string tag, input int cid, input int op, input int ad,
                        input int a, input int b, input bit w);
    int exp;
    exp     = model_exec(op, ad, a, b, w);
    core_id = CIDW'(cid);
    opcode  = 3'(op);
    addr    = AW'(ad);
    A       = DW'(a);
    B       = DW'(b);
    we      = w;
    req     = 1'b1;
    @(posedge clk); #1;
    check({tag, ".gnt"}, 32'(gnt), 32'd1);
    check({tag, ".rv0"}, 32'(rvalid), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, ".gnt_lo"}, 32'(gnt), 32'd0);
    check({tag, ".rv1"}, 32'(rvalid), 32'd1);
    check({tag, ".data"}, 32'(data_out), 32'(exp));
    check({tag, ".cid"}, 32'(core_id_out), 32'(cid));
    @(posedge clk); #1;
    check({tag, ".rv_lo"}, 32'(rvalid), 32'd0);
  endtask

  int pool [8] = '{0, 5, 16, 100, 511, 1024, 2000, 2047};

  initial begin
    int op, ad;
    bit w;
    n_checks = 0;
    n_errors = 0;

    // Reset held with req asserted: nothing may happen.
    rst_n = 1'b0; req = 1'b1; core_id = 2'd3; opcode = 3'd0;
    addr = '0; A = 8'h11; B = 8'h22; we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst.gnt", 32'(gnt), 32'd0);
      check("rst.rvalid", 32'(rvalid), 32'd0);
      check("rst.data", 32'(data_out), 32'd0);
      check("rst.cid", 32'(core_id_out), 32'd0);
    end
    req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle.gnt", 32'(gnt), 32'd0);

    // Directed cases.
    do_txn("add", 2, 0, 0, 8'hF0, 8'h20, 1'b0);
    do_txn("st7ff", 1, 7, 11'h7FF, 8'h5A, 8'h00, 1'b1);
    do_txn("ld7ff", 3, 7, 11'h7FF, 8'h00, 8'h00, 1'b0);
    do_txn("mulwb", 0, 5, 11'h010, 8'h13, 8'h11, 1'b1);
    do_txn("ld010", 2, 7, 11'h010, 8'h00, 8'h00, 1'b0);
    do_txn("sub", 1, 1, 0, 8'h10, 8'h20, 1'b0);
    do_txn("rsvd", 3, 6, 0, 8'hFF, 8'hFF, 1'b0);

    // req held high: one grant every 3 cycles, each followed by one rvalid.
    core_id = 2'd1; opcode = 3'd4; addr = '0; A = 8'h3C; B = 8'h0F; we = 1'b0;
    req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check("hold.gnt", 32'(gnt), 32'((k % 3) == 0));
      check("hold.rvalid", 32'(rvalid), 32'((k % 3) == 1));
      if ((k % 3) == 1) check("hold.data", 32'(data_out), 32'h33);
    end
    req = 1'b0;
    @(posedge clk); #1;
    check("hold.end", 32'(gnt), 32'd0);

    // Reset during GRANT of a store: no response and no write.
    do_txn("pre005", 0, 7, 5, 8'h33, 8'h00, 1'b1);
    core_id = 2'd2; opcode = 3'd7; addr = 11'd5; A = 8'hAA; we = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    check("mid.gnt", 32'(gnt), 32'd1);
    req = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid.rvalid0", 32'(rvalid), 32'd0);
    check("mid.data", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid.rvalid1", 32'(rvalid), 32'd0);
    do_txn("post005", 3, 7, 5, 8'h00, 8'h00, 1'b0);

    // Randomized traffic over a small address pool.
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 7));
      ad = pool[$urandom_range(0, 7)];
      w  = bit'($urandom_range(0, 1));
      if (op == 7 && !w && !mem_m.exists(ad)) w = 1'b1;
      do_txn("rand", int'($urandom_range(0, 3)), op, ad,
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
